// File: rtl/dmem_bus_arbiter.sv
// Two-master, one-slave data bus arbiter with round-robin/fixed grant and a per-transaction
// timeout that completes the master with an error pulse instead of hanging the bus.
module dmem_bus_arbiter #(
   parameter bit          RR_EN    = 1'b1,
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   input  logic        m0_wen,
   input  logic        m0_ren,
   output logic        m0_ready,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   input  logic        m1_wen,
   input  logic        m1_ren,
   output logic        m1_ready,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   output logic        s_wen,
   output logic        s_ren,
   input  logic        s_wready,
   input  logic [31:0] s_rdata,
   input  logic        s_rvalid
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWr   = 2'd1;
   localparam logic [1:0] StRd   = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic        last_q, last_d;
   logic        gnt_q, gnt_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] s_addr_q, s_addr_d;
   logic [31:0] s_wdata_q, s_wdata_d;
   logic [3:0]  s_wstrb_q, s_wstrb_d;
   logic        s_wen_q, s_wen_d;
   logic        s_ren_q, s_ren_d;
   logic [1:0]  ready_q, ready_d;
   logic [1:0]  rvalid_q, rvalid_d;
   logic [1:0]  err_q, err_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;

   logic        req0, req1, win, win_wr, timeout;
   logic [31:0] rd_val;

   assign req0    = m0_wen | m0_ren;
   assign req1    = m1_wen | m1_ren;
   // M1 wins when alone, or on a tie when round-robin is on and M0 was served last.
   assign win     = req1 & (~req0 | (RR_EN & ~last_q));
   assign win_wr  = win ? m1_wen : m0_wen;
   assign timeout = (cnt_q == CntLast);
   assign rd_val  = s_rvalid ? s_rdata : ERR_DATA;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_wstrb_d = s_wstrb_q;
      s_wen_d   = s_wen_q;
      s_ren_d   = s_ren_q;
      ready_d   = 2'b00;
      rvalid_d  = 2'b00;
      err_d     = 2'b00;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      case (state_q)
         StIdle: begin
            if (req0 | req1) begin
               gnt_d     = win;
               last_d    = win;
               cnt_d     = 8'd0;
               s_addr_d  = win ? m1_addr : m0_addr;
               s_wdata_d = win ? m1_wdata : m0_wdata;
               s_wstrb_d = win ? m1_wstrb : m0_wstrb;
               s_wen_d   = win_wr;
               s_ren_d   = ~win_wr;
               state_d   = win_wr ? StWr : StRd;
            end
         end
         StWr: begin
            cnt_d = cnt_q + 8'd1;
            if (s_wready || timeout) begin
               s_wen_d        = 1'b0;
               ready_d[gnt_q] = 1'b1;
               err_d[gnt_q]   = ~s_wready;
               state_d        = StDone;
            end
         end
         StRd: begin
            cnt_d = cnt_q + 8'd1;
            if (s_rvalid || timeout) begin
               s_ren_d         = 1'b0;
               rvalid_d[gnt_q] = 1'b1;
               err_d[gnt_q]    = ~s_rvalid;
               if (gnt_q) rdata1_d = rd_val;
               else       rdata0_d = rd_val;
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         gnt_q     <= 1'b0;
         cnt_q     <= 8'd0;
         s_addr_q  <= 32'd0;
         s_wdata_q <= 32'd0;
         s_wstrb_q <= 4'd0;
         s_wen_q   <= 1'b0;
         s_ren_q   <= 1'b0;
         ready_q   <= 2'b00;
         rvalid_q  <= 2'b00;
         err_q     <= 2'b00;
         rdata0_q  <= 32'd0;
         rdata1_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_wstrb_q <= s_wstrb_d;
         s_wen_q   <= s_wen_d;
         s_ren_q   <= s_ren_d;
         ready_q   <= ready_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign s_addr    = s_addr_q;
   assign s_wdata   = s_wdata_q;
   assign s_wstrb   = s_wstrb_q;
   assign s_wen     = s_wen_q;
   assign s_ren     = s_ren_q;
   assign m0_ready  = ready_q[0];
   assign m1_ready  = ready_q[1];
   assign m0_rvalid = rvalid_q[0];
   assign m1_rvalid = rvalid_q[1];
   assign m0_err    = err_q[0];
   assign m1_err    = err_q[1];
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;

endmodule
